// File: rtl/sseg_mux_driver.sv
// Time-multiplexed multi-digit 7-segment driver with a shadow register,
// refresh prescaler, leading-zero blanking, optional hex glyphs and pin polarity.
module sseg_mux_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 1000,
  parameter int HEX_EN      = 0,
  parameter int LZ_BLANK    = 1,
  parameter int ACTIVE_LOW  = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    enable,
  output logic [6:0]              sseg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int PRE_W = $clog2(REFRESH_DIV);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] LAST_PRE = PRE_W'(REFRESH_DIV - 1);

  logic [4*NUM_DIGITS-1:0] codes_q, codes_d;
  logic [NUM_DIGITS-1:0]   dps_q, dps_d;
  logic [PRE_W-1:0]        presc_q, presc_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic                    frame_q, frame_d;
  logic [6:0]              sseg_q, sseg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic [3:0] cur_code;
  logic       cur_dp;
  logic       cur_blank;
  logic       zero_run;

  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    case (code)
      4'd0:    g = 7'b1111110;
      4'd1:    g = 7'b0110000;
      4'd2:    g = 7'b1101101;
      4'd3:    g = 7'b1111001;
      4'd4:    g = 7'b0110011;
      4'd5:    g = 7'b1011011;
      4'd6:    g = 7'b1011111;
      4'd7:    g = 7'b1110000;
      4'd8:    g = 7'b1111111;
      4'd9:    g = 7'b1111011;
      4'd10:   g = 7'b1110111;
      4'd11:   g = 7'b0011111;
      4'd12:   g = 7'b1001110;
      4'd13:   g = 7'b0111101;
      4'd14:   g = 7'b1001111;
      default: g = 7'b1000111;
    endcase
    if (HEX_EN == 0 && code > 4'd9) g = 7'b0000000;
    return g;
  endfunction

  always_comb begin
    codes_d   = load ? digits_in : codes_q;
    dps_d     = load ? dp_in : dps_q;
    presc_d   = presc_q;
    idx_d     = idx_q;
    frame_d   = 1'b0;
    an_d      = '0;
    sseg_d    = 7'b0000000;
    dp_d      = 1'b0;
    cur_code  = 4'd0;
    cur_dp    = 1'b0;
    cur_blank = 1'b0;
    zero_run  = 1'b1;

    if (enable) begin
      if (presc_q == LAST_PRE) begin
        presc_d = '0;
        if (idx_q == LAST_IDX) begin
          idx_d   = '0;
          frame_d = 1'b1;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end

    // Walk from the top digit down; a digit is blankable while every digit above it is zero.
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      zero_run = zero_run & (codes_q[4*k +: 4] == 4'd0);
      if (idx_q == IDX_W'(k)) begin
        cur_code  = codes_q[4*k +: 4];
        cur_dp    = dps_q[k];
        cur_blank = zero_run && (k != 0) && (LZ_BLANK != 0);
        an_d[k]   = enable;
      end
    end

    if (enable) begin
      sseg_d = cur_blank ? 7'b0000000 : glyph(cur_code);
      dp_d   = cur_dp;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      codes_q <= '0;
      dps_q   <= '0;
      presc_q <= '0;
      idx_q   <= '0;
      frame_q <= 1'b0;
      sseg_q  <= 7'b0000000;
      dp_q    <= 1'b0;
      an_q    <= '0;
    end else begin
      codes_q <= codes_d;
      dps_q   <= dps_d;
      presc_q <= presc_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      sseg_q  <= sseg_d;
      dp_q    <= dp_d;
      an_q    <= an_d;
    end
  end

  assign sseg       = (ACTIVE_LOW != 0) ? ~sseg_q : sseg_q;
  assign dp         = (ACTIVE_LOW != 0) ? ~dp_q : dp_q;
  assign an         = (ACTIVE_LOW != 0) ? ~an_q : an_q;
  assign frame_done = frame_q;

endmodule
